instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 145 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues word-aligned fetches to instruction memory under a credit
// limit, buffers returned words with their addresses in a small FIFO for decode, and
// discards responses belonging to requests issued before a redirect.
//
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   imem_req_valid/addr/ready       fetch request channel (request need not be held)
//   imem_rsp_valid/data             in-order fetch responses, >= 1 cycle after acceptance
//   redirect_valid/pc               one-cycle branch/jump redirect
//   instr_valid/instr/instr_pc      instruction presented to decode
//   instr_ready                     decode consumes the presented instruction
module instr_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [63:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [63:0] instr_pc,
  input  logic        instr_ready
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = CW + 2;

  typedef enum logic [0:0] {StRun, StDrain} state_e;

  state_e        state_q, state_d;
  logic [63:0]   pc_q, pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] live_q, live_d;
  logic [CW-1:0] drop_q, drop_d;

  logic [31:0]   fifo_word_q [DEPTH];
  logic [63:0]   fifo_pc_q   [DEPTH];
  logic [PW-1:0] head_q, tail_q;

  // Addresses of outstanding requests, oldest first; paired with responses as they return.
  logic [63:0]   pend_q [DEPTH];
  logic [PW-1:0] pend_head_q, pend_tail_q;

  logic          accept, push, pop, rsp_live;
  logic [SW-1:0] in_flight;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Every outstanding request and every buffered word holds one FIFO slot, so a returning
  // response can never find the FIFO full.
  assign in_flight      = SW'(live_q) + SW'(drop_q) + SW'(count_q);
  assign imem_req_valid = !rst && !redirect_valid && (in_flight < SW'(DEPTH));
  assign imem_req_addr  = pc_q;
  assign accept         = imem_req_valid && imem_req_ready;

  assign rsp_live = imem_rsp_valid && (drop_q == '0);
  assign push     = rsp_live && !redirect_valid;

  assign instr_valid = !rst && (count_q != '0);
  assign instr       = instr_valid ? fifo_word_q[head_q] : '0;
  assign instr_pc    = instr_valid ? fifo_pc_q[head_q] : '0;
  assign pop         = instr_valid && instr_ready;

  always_comb begin
    pc_d    = pc_q;
    count_d = count_q;
    live_d  = live_q;
    drop_d  = drop_q;
    if (redirect_valid) begin
      pc_d    = redirect_pc & ~64'h3;
      count_d = '0;
      live_d  = '0;
      // Whichever class the same-cycle response belonged to, it is retired now.
      drop_d  = drop_q + live_q - CW'(imem_rsp_valid);
    end else begin
      if (accept) pc_d = pc_q + 64'd4;
      live_d  = live_q + CW'(accept) - CW'(rsp_live);
      drop_d  = drop_q - CW'(imem_rsp_valid && (drop_q != '0));
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (redirect_valid && (drop_d != '0)) state_d = StDrain;
      StDrain: if (!redirect_valid && (drop_d == '0)) state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StRun;
      pc_q        <= RESET_PC;
      count_q     <= '0;
      live_q      <= '0;
      drop_q      <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      pend_head_q <= '0;
      pend_tail_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      live_q  <= live_d;
      drop_q  <= drop_d;
      if (redirect_valid) begin
        head_q <= '0;
        tail_q <= '0;
      end else begin
        if (push) tail_q <= ptr_inc(tail_q);
        if (pop)  head_q <= ptr_inc(head_q);
      end
      if (accept)         pend_tail_q <= ptr_inc(pend_tail_q);
      if (imem_rsp_valid) pend_head_q <= ptr_inc(pend_head_q);
    end
  end

  // Storage arrays carry no reset; validity is tracked by the pointers and counters.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      fifo_word_q[tail_q] <= imem_rsp_data;
      fifo_pc_q[tail_q]   <= pend_q[pend_head_q];
    end
    if (!rst && accept) begin
      pend_q[pend_tail_q] <= pc_q;
    end
  end

  // Overflow is unreachable while the credit rule holds.
  assert property (@(posedge clk) disable iff (rst) !(push && !pop && (count_q == CW'(DEPTH))))
    else $error("instr_fetch_unit: instruction FIFO overflow");

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [63:0] imem_req_addr;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        instr_valid, instr_ready;
  logic [31:0] instr;
  logic [63:0] instr_pc;

  // Second instance for the address wrap case; its memory never responds.
  logic        w_req_valid, w_instr_valid;
  logic [63:0] w_req_addr, w_instr_pc;
  logic [31:0] w_instr;

  int   checks = 0;
  int   errors = 0;
  int   acc_cnt = 0;
  int   base;
  logic mem_stall;
  logic [63:0] mq[$];

  instr_fetch_unit #(.RESET_PC(64'h0), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
    .instr_ready(instr_ready)
  );

  instr_fetch_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC), .DEPTH(2)) dut_wrap (
    .clk(clk), .rst(rst),
    .imem_req_valid(w_req_valid), .imem_req_addr(w_req_addr),
    .imem_req_ready(1'b1),
    .imem_rsp_valid(1'b0), .imem_rsp_data(32'h0),
    .redirect_valid(1'b0), .redirect_pc(64'h0),
    .instr_valid(w_instr_valid), .instr(w_instr), .instr_pc(w_instr_pc),
    .instr_ready(1'b1)
  );

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  // Memory model: 1-cycle latency, in order; mem_stall holds responses back.
  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
    end else if (imem_req_valid && imem_req_ready) begin
      mq.push_back(imem_req_addr);
      acc_cnt++;
    end
    #1;
    if (!rst && !mem_stall && mq.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_of(mq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 64'h0;
    imem_req_ready = 1'b1; instr_ready = 1'b1; mem_stall = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    tick(); tick();
    chk("rst_req_valid",   64'(imem_req_valid), 64'd0);
    chk("rst_instr_valid", 64'(instr_valid), 64'd0);
    chk("rst_instr",       64'(instr), 64'd0);
    chk("rst_instr_pc",    instr_pc, 64'd0);

    // Straight-line fetch, 1-cycle memory
    rst = 1'b0; #1;
    chk("c0_req_valid", 64'(imem_req_valid), 64'd1);
    chk("c0_req_addr",  imem_req_addr, 64'h0);
    chk("wrap_first_addr", w_req_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick();
    chk("c1_req_addr",    imem_req_addr, 64'h4);
    chk("c1_instr_valid", 64'(instr_valid), 64'd0);
    chk("wrap_second_valid", 64'(w_req_valid), 64'd1);
    chk("wrap_second_addr",  w_req_addr, 64'h0);
    chk("wrap_no_instr", {31'h0, w_instr_valid, w_instr}, 64'h0);
    chk("wrap_no_instr_pc", w_instr_pc, 64'h0);
    tick();
    chk("c2_instr_valid", 64'(instr_valid), 64'd1);
    chk("c2_instr_pc",    instr_pc, 64'h0);
    chk("c2_instr",       64'(instr), 64'(word_of(64'h0)));
    chk("c2_no_credit",   64'(imem_req_valid), 64'd0);
    tick();
    chk("c3_instr_pc", instr_pc, 64'h4);
    chk("c3_instr",    64'(instr), 64'(word_of(64'h4)));
    chk("c3_req_addr", imem_req_addr, 64'h8);
    tick();
    chk("c4_instr_valid", 64'(instr_valid), 64'd0);
    chk("c4_req_addr",    imem_req_addr, 64'hC);
    tick();
    chk("c5_instr_pc", instr_pc, 64'h8);
    chk("c5_instr",    64'(instr), 64'(word_of(64'h8)));

    // Decode stalled: buffer fills after two requests and the head holds
    rst = 1'b1; instr_ready = 1'b0;
    tick();
    chk("rst2_instr_valid", 64'(instr_valid), 64'd0);
    rst = 1'b0; #1;
    base = acc_cnt;
    chk("d0_req_addr", imem_req_addr, 64'h0);
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_instr_valid", 64'(instr_valid), 64'd1);
      chk("stall_instr_pc",    instr_pc, 64'h0);
      chk("stall_instr",       64'(instr), 64'(word_of(64'h0)));
      chk("stall_no_req",      64'(imem_req_valid), 64'd0);
    end
    chk("stall_accepts", 64'(acc_cnt - base), 64'd2);

    // Redirect with two requests outstanding
    rst = 1'b1; instr_ready = 1'b1; mem_stall = 1'b1;
    tick();
    rst = 1'b0; redirect_valid = 1'b1; redirect_pc = 64'h10; #1;
    chk("f0_redirect_no_req", 64'(imem_req_valid), 64'd0);
    tick();
    redirect_valid = 1'b0; #1;
    chk("f1_req_addr", imem_req_addr, 64'h10);
    tick();
    chk("f2_req_addr", imem_req_addr, 64'h14);
    tick();
    chk("f3_no_credit", 64'(imem_req_valid), 64'd0);
    redirect_valid = 1'b1; redirect_pc = 64'h103; mem_stall = 1'b0; #1;
    chk("f3_redirect_no_req", 64'(imem_req_valid), 64'd0);
    tick();
    redirect_valid = 1'b0; #1;
    chk("f4_state_drain", 64'(dut.state_q), 64'd1);
    chk("f4_drop",        64'(dut.drop_q), 64'd2);
    chk("f4_no_req",      64'(imem_req_valid), 64'd0);
    chk("f4_flushed",     64'(instr_valid), 64'd0);
    tick();
    chk("f5_drop",     64'(dut.drop_q), 64'd1);
    chk("f5_req_addr", imem_req_addr, 64'h100);
    tick();
    chk("f6_state_run", 64'(dut.state_q), 64'd0);
    chk("f6_drop",      64'(dut.drop_q), 64'd0);
    tick();
    chk("f7_instr_pc", instr_pc, 64'h100);
    chk("f7_instr",    64'(instr), 64'(word_of(64'h100)));

    // Redirect coinciding with a live response and a pop
    redirect_valid = 1'b1; redirect_pc = 64'h200; #1;
    chk("f7_pop_valid", 64'(instr_valid), 64'd1);
    chk("f7_no_req",    64'(imem_req_valid), 64'd0);
    tick();
    redirect_valid = 1'b0; #1;
    chk("f8_flushed",  64'(instr_valid), 64'd0);
    chk("f8_drop",     64'(dut.drop_q), 64'd0);
    chk("f8_state",    64'(dut.state_q), 64'd0);
    chk("f8_req_addr", imem_req_addr, 64'h200);
    tick();
    chk("f9_instr_valid", 64'(instr_valid), 64'd0);
    chk("f9_req_addr",    imem_req_addr, 64'h204);
    tick();
    chk("f10_instr_pc", instr_pc, 64'h200);
    chk("f10_instr",    64'(instr), 64'(word_of(64'h200)));
    mem_stall = 1'b1;

    // Reset during drain with one request outstanding
    tick();
    chk("f11_instr_pc", instr_pc, 64'h204);
    chk("f11_req_addr", imem_req_addr, 64'h208);
    tick();
    redirect_valid = 1'b1; redirect_pc = 64'h300; #1;
    tick();
    redirect_valid = 1'b0; imem_req_ready = 1'b0; #1;
    chk("f13_state_drain", 64'(dut.state_q), 64'd1);
    chk("f13_drop",        64'(dut.drop_q), 64'd1);
    chk("f13_req_addr",    imem_req_addr, 64'h300);
    rst = 1'b1;
    tick();
    chk("f14_rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("f14_rst_drop",      64'(dut.drop_q), 64'd0);
    rst = 1'b0; imem_req_ready = 1'b1; mem_stall = 1'b0; #1;
    chk("post_rst_req_valid",   64'(imem_req_valid), 64'd1);
    chk("post_rst_req_addr",    imem_req_addr, 64'h0);
    chk("post_rst_instr_valid", 64'(instr_valid), 64'd0);
    chk("post_rst_drop",        64'(dut.drop_q), 64'd0);
    chk("post_rst_state",       64'(dut.state_q), 64'd0);
    tick();
    chk("post_rst_req_addr2", imem_req_addr, 64'h4);
    tick();
    chk("post_rst_instr_pc", instr_pc, 64'h0);
    chk("post_rst_instr",    64'(instr), 64'(word_of(64'h0)));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
